// File: rtl/coin_change_dispenser.sv
// Pays out change owed (units of 100) as 500/100 coins, one ack handshake per coin.
// Define COIN_COUNT_EN to add per-payout coin counters on ports cnt500/cnt100.
module coin_change_dispenser (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] amount,
  input  logic       ack,
  output logic       give500,
  output logic       give100,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef COIN_COUNT_EN
  ,
  output logic [3:0] cnt500,
  output logic [3:0] cnt100
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EVAL   = 3'd1,
    PAY500 = 3'd2,
    PAY100 = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t     state_reg, state_next;
  logic [5:0] rem_reg, rem_next;
  logic [7:0] tmo_reg, tmo_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rem_reg   <= 6'd0;
      tmo_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      tmo_reg   <= tmo_next;
    end
  end

  // The timeout counter only lives in the PAY states; it reads zero on every entry.
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    tmo_next   = 8'd0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          rem_next   = amount;
          state_next = EVAL;
        end
      end
      EVAL: begin
        if (rem_reg >= 6'd5)
          state_next = PAY500;
        else if (rem_reg != 6'd0)
          state_next = PAY100;
        else
          state_next = DONE;
      end
      PAY500, PAY100: begin
        if (ack) begin
          rem_next   = (state_reg == PAY500) ? (rem_reg - 6'd5) : (rem_reg - 6'd1);
          state_next = GAP;
        end else begin
          tmo_next = tmo_reg + 8'd1;
          if (tmo_reg == 8'd254)
            state_next = ERR;
        end
      end
      GAP: begin
        if (!ack)
          state_next = EVAL;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign give500 = (state_reg == PAY500);
  assign give100 = (state_reg == PAY100);
  assign done    = (state_reg == DONE);
  assign err     = (state_reg == ERR);
  assign busy    = (state_reg != IDLE);

`ifdef COIN_COUNT_EN
  logic [3:0] cnt500_reg, cnt100_reg;

  // Counts survive DONE/ERR so the last payout can be read back until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt500_reg <= 4'd0;
      cnt100_reg <= 4'd0;
    end else if (state_reg == IDLE && start) begin
      cnt500_reg <= 4'd0;
      cnt100_reg <= 4'd0;
    end else if (ack) begin
      if (state_reg == PAY500)
        cnt500_reg <= cnt500_reg + 4'd1;
      if (state_reg == PAY100)
        cnt100_reg <= cnt100_reg + 4'd1;
    end
  end

  assign cnt500 = cnt500_reg;
  assign cnt100 = cnt100_reg;
`endif

endmodule

// File: doc/coin_change_dispenser.md
COIN_CHANGE_DISPENSER -- requirements
Module: coin_change_dispenser

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising-edge active.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: start  in  1  request to pay out change; sampled only in IDLE.
REQ-004 SHALL have ports: amount  in  6  change owed in units of 100 (0..63, i.e. 0..6300).
REQ-005 SHALL have ports: ack  in  1  coin-mechanism acknowledge; high means the coin has dropped.
REQ-006 SHALL have ports: give500  out  1  request the mechanism to drop one 500 coin.
REQ-007 SHALL have ports: give100  out  1  request the mechanism to drop one 100 coin.
REQ-008 SHALL have ports: busy  out  1  payout in progress.
REQ-009 SHALL have ports: done  out  1  one-cycle pulse when payout completes.
REQ-010 SHALL have ports: err  out  1  one-cycle pulse on mechanism timeout.

Function
REQ-011 SHALL implement the states IDLE, EVAL, PAY500, PAY100, GAP, DONE and ERR.
REQ-012 SHALL decode all outputs from the registered state (Moore).
- give500 = PAY500; give100 = PAY100; done = DONE; err = ERR; busy = any state except IDLE.
REQ-013 SHALL, in IDLE with start=1, latch amount into a 6-bit remainder register rem and go to EVAL.
- start=0 in IDLE: remain in IDLE.
REQ-014 SHALL, in EVAL, go to PAY500 if rem>=5, else PAY100 if rem>=1, else DONE.
- First coin request appears 2 cycles after the start sample.
REQ-015 SHALL, in PAY500 or PAY100, hold the give output high until ack=1.
- On ack: subtract 5 or 1 from rem respectively, clear the timeout counter, go to GAP.
REQ-016 SHALL, in GAP, deassert both give outputs and wait until ack=0, then go to EVAL.
- Each coin therefore requires a full ack high/low handshake.
REQ-017 SHALL never assert give500 and give100 in the same cycle.
REQ-018 SHALL run an 8-bit timeout counter in PAY500/PAY100 that increments each cycle ack=0.
- Reaching 255 goes to ERR; the give output drops in that cycle.
REQ-019 SHALL spend exactly one cycle in DONE or ERR, then return to IDLE.
REQ-020 SHALL ignore start whenever busy=1.
- amount is sampled only on the IDLE start cycle; later changes have no effect.
REQ-021 SHALL treat amount=0 as a valid request: no coins, done pulses 2 cycles after start.
REQ-022 SHALL never underflow rem.
- Subtraction happens only after the EVAL comparison guarantees rem>=5 or rem>=1.

Reset
REQ-023 SHALL, on rst=1, immediately force state=IDLE, rem=0 and timeout counter=0 regardless of clk.
REQ-024 SHALL hold all outputs low during reset, including mid-payout.
- A payout interrupted by reset is abandoned, not resumed.

Configuration
REQ-025 SHALL support macro COIN_COUNT_EN; when defined, add two ports:
- cnt500  out  4  count of 500 coins dropped in the current/last payout.
- cnt100  out  4  count of 100 coins dropped in the current/last payout.
REQ-026 SHALL, with COIN_COUNT_EN defined:
- clear both counts on the accepted start;
- increment the matching count on each ack accepted in PAY500/PAY100;
- hold the counts after DONE/ERR until the next start;
- reset both counts to 0 on rst.
REQ-027 SHALL, without COIN_COUNT_EN, omit the cnt500/cnt100 ports and counters entirely; all other behaviour is identical.

Verification
REQ-028 SHALL cover: amount=7, ack 1 cycle after each give, low 1 cycle later -> give500 x1, give100 x2, then one done pulse, busy low.
REQ-029 SHALL cover: amount=0 -> no give, done high exactly 2 cycles after start, err never.
REQ-030 SHALL cover: amount=5, ack held 0 -> give500 high 255 cycles, then one err pulse, busy low, no done.
REQ-031 SHALL cover: amount=10, rst pulsed while give500=1 -> give500, busy and rem low immediately; next start with amount=1 yields a single give100.
REQ-032 SHALL cover: start re-pulsed with amount=63 during an amount=2 payout -> exactly two give100, ignored start has no effect.
REQ-033 SHALL cover, with COIN_COUNT_EN: amount=12 -> cnt500=2, cnt100=2 after done; both cleared on the next start.
